// File: rtl/rom_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter_pkg : shared defaults and requester index type (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package rom_port_arbiter_pkg;

   localparam int NREQ_DEF   = 3;
   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 8;

   localparam int REQ_IDX_W  = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

   typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage

`default_nettype wire

// File: rtl/rom_port_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin winner search from last_grant+1 (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
   import rom_port_arbiter_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  valid,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] winner
);

   logic found;

   always_comb begin
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (int'(ptr) + 1 + k) % NREQ;
         if (!found && valid[idx]) begin
            found      = 1'b1;
            winner     = IDX_W'(idx);
            grant[idx] = en;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter : round-robin sharing of one synchronous ROM port (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module rom_port_arbiter
   import rom_port_arbiter_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                          vga_clk,
   input  logic                          reset_n,
   input  logic                          en,
   input  logic [NREQ-1:0]               req_valid,
   input  logic [NREQ-1:0][ADDR_W-1:0]   req_addr,
   output logic [NREQ-1:0]               req_ready,
   output logic [ADDR_W-1:0]             rom_address,
   input  logic [DATA_W-1:0]             rom_q,
   output logic [NREQ-1:0]               rsp_valid,
   output logic [DATA_W-1:0]             rsp_data
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDX_W-1:0]  last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] rom_address_q, rom_address_d;
   logic [IDX_W-1:0]  tag_q, tag_d;
   logic              s1_valid_q, s1_valid_d;
   logic [IDX_W-1:0]  rd_tag_q, rd_tag_d;
   logic              rd_valid_q, rd_valid_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic [NREQ-1:0]   grant;
   logic [IDX_W-1:0]  win_idx;
   logic              handshake;
   logic [ADDR_W-1:0] win_addr;

   // Reset gates the grant so nothing is offered while the pipeline is held clear.
   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .valid  (req_valid),
      .ptr    (last_grant_q),
      .en     (en & reset_n),
      .grant  (grant),
      .winner (win_idx)
   );

   assign req_ready = grant;
   assign handshake = |(grant & req_valid);

   always_comb begin
      win_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_addr = req_addr[i];
         end
      end
   end

   // rd_* tracks the cycle in which the ROM holds its internally registered read.
   always_comb begin
      last_grant_d  = handshake ? win_idx  : last_grant_q;
      rom_address_d = handshake ? win_addr : rom_address_q;
      tag_d         = handshake ? win_idx  : tag_q;
      s1_valid_d    = handshake;
      rd_tag_d      = tag_q;
      rd_valid_d    = s1_valid_q;
      rsp_valid_d   = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_valid_d[i] = rd_valid_q && (rd_tag_q == IDX_W'(i));
      end
      rsp_data_d    = rd_valid_q ? rom_q : rsp_data_q;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q  <= IDX_W'(NREQ - 1);
         rom_address_q <= '0;
         tag_q         <= '0;
         s1_valid_q    <= 1'b0;
         rd_tag_q      <= '0;
         rd_valid_q    <= 1'b0;
         rsp_valid_q   <= '0;
         rsp_data_q    <= '0;
      end else begin
         last_grant_q  <= last_grant_d;
         rom_address_q <= rom_address_d;
         tag_q         <= tag_d;
         s1_valid_q    <= s1_valid_d;
         rd_tag_q      <= rd_tag_d;
         rd_valid_q    <= rd_valid_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
      end
   end

   assign rom_address = rom_address_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_port_arbiter : directed + random stimulus against a queue-based model (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rom_port_arbiter;

   localparam int NREQ   = 3;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;

   logic                        vga_clk = 1'b0;
   logic                        reset_n;
   logic                        en;
   logic [NREQ-1:0]             req_valid;
   logic [NREQ-1:0][ADDR_W-1:0] req_addr;
   logic [NREQ-1:0]             req_ready;
   logic [ADDR_W-1:0]           rom_address;
   logic [DATA_W-1:0]           rom_q;
   logic [NREQ-1:0]             rsp_valid;
   logic [DATA_W-1:0]           rsp_data;

   always #5 vga_clk = ~vga_clk;

   rom_port_arbiter #(
      .NREQ   (NREQ),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .en          (en),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .rom_address (rom_address),
      .rom_q       (rom_q),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data)
   );

   // Synchronous ROM: address sampled on the edge, data visible one cycle later.
   logic [DATA_W-1:0] rom_mem [0:(1<<ADDR_W)-1];
   always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

   typedef struct {
      int due;
      int tag;
      int data;
   } rsp_t;

   rsp_t q[$];
   int   m_last;
   int   m_data;
   int   m_addr;
   int   cyc;
   int   n_tests;
   int   n_fail;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic int model_winner(input int last, input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      q.delete();
      m_last = NREQ - 1;
      m_data = 0;
      m_addr = 0;
   endtask

   task automatic set_reset(input logic v);
      reset_n = v;
      if (!v) model_reset();
   endtask

   // Inputs are applied at the falling edge before calling; one call = one clock.
   task automatic step();
      int w;
      #1;
      w = (reset_n && en) ? model_winner(m_last, req_valid) : -1;
      check_val("req_ready", int'(req_ready), (w >= 0) ? (1 << w) : 0);
      if (q.size() > 0 && q[0].due == cyc) begin
         check_val("rsp_valid", int'(rsp_valid), 1 << q[0].tag);
         check_val("rsp_data", int'(rsp_data), q[0].data);
         m_data = q[0].data;
         void'(q.pop_front());
      end else begin
         check_val("rsp_valid_idle", int'(rsp_valid), 0);
         check_val("rsp_data_hold", int'(rsp_data), m_data);
      end
      check_val("rom_address", int'(rom_address), m_addr);
      @(posedge vga_clk);
      cyc++;
      if (w >= 0) begin
         m_last = w;
         m_addr = int'(req_addr[w]);
         q.push_back('{due: cyc + 2, tag: w, data: int'(rom_mem[req_addr[w]])});
      end
      @(negedge vga_clk);
   endtask

   task automatic drive(input logic [NREQ-1:0] v, input int n);
      req_valid = v;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = DATA_W'($urandom);
      en        = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      set_reset(1'b0);
      drive(3'b000, 2);
      set_reset(1'b1);

      // All three valid: strict rotation 0,1,2,...
      req_addr[0] = 10'd5;
      req_addr[1] = 10'd6;
      req_addr[2] = 10'd7;
      drive(3'b111, 8);
      drive(3'b000, 4);

      // Single request at the top address
      req_addr[2] = 10'd1023;
      drive(3'b100, 1);
      drive(3'b000, 4);

      // After a grant to 1, requester 2 outranks 0
      drive(3'b010, 1);
      drive(3'b101, 2);
      drive(3'b000, 3);

      // Drop en after back-to-back grants; in-flight reads drain
      drive(3'b111, 2);
      en = 1'b0;
      drive(3'b111, 3);
      en = 1'b1;
      drive(3'b000, 2);

      // Reset one cycle after a handshake discards the in-flight read
      drive(3'b010, 1);
      req_valid = '0;
      set_reset(1'b0);
      step();
      set_reset(1'b1);
      drive(3'b000, 3);
      drive(3'b111, 1);
      drive(3'b000, 3);

      // Long idle
      drive(3'b000, 10);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         for (int r = 0; r < NREQ; r++) req_addr[r] = ADDR_W'($urandom);
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 63) == 0) begin
            set_reset(1'b0);
            drive(NREQ'($urandom), 1);
            set_reset(1'b1);
         end else begin
            drive(NREQ'($urandom), 1);
         end
      end
      en = 1'b1;
      drive(3'b000, 4);
      check_val("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
